// File: rtl/vga_pkg.sv
// Shared VGA scan timing: default 640x480@60 constants, totals, phase enum and
// the phase step function used by both scan axes.
package vga_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    localparam int unsigned DEF_CLK_DIV   = 2;
    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } scan_phase_t;

    // Phase for the counter value about to be loaded; cnt is the new position.
    function automatic scan_phase_t next_phase(
        input scan_phase_t      cur,
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] fp_start,
        input logic [CNT_W-1:0] sync_start,
        input logic [CNT_W-1:0] bp_start
    );
        scan_phase_t nxt;
        nxt = cur;
        case (cur)
            ACTIVE:  if (cnt == fp_start)   nxt = FRONT;
            FRONT:   if (cnt == sync_start) nxt = SYNC;
            SYNC:    if (cnt == bp_start)   nxt = BACK;
            BACK:    if (cnt == '0)         nxt = ACTIVE;
            default: nxt = ACTIVE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel-rate enable: divides the system clock by CLK_DIV into a one-clock pix_tick.
module pix_clk_en #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_pix_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_div_chk
        $error("pix_clk_en: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_d;
    logic             r_tick;
    logic             w_tick_d;

    // While paused the pending tick is kept, so resuming never drops a pixel.
    always_comb begin
        w_div_d  = r_div;
        w_tick_d = r_tick;
        if (i_en) begin
            w_tick_d = (r_div == DIV_LAST);
            w_div_d  = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_div_d;
            r_tick <= w_tick_d;
        end
    end

    assign o_pix_tick = r_tick & i_en;

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan counters, phase FSMs, syncs and line/frame markers.
// Optional VGA_FRAME_CNT_EN adds a 16-bit wrapping frame counter output.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic             o_pix_tick,
    output logic [CNT_W-1:0] o_hcount,
    output logic [CNT_W-1:0] o_vcount,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_video_on,
    output logic             o_line_start,
    output logic             o_frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      o_frame_count
`endif
);

    localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if (H_TOT > CNT_MAX) begin : g_h_total_chk
        $error("vga_scan_ctrl: horizontal total exceeds 10-bit counter range");
    end
    if (V_TOT > CNT_MAX) begin : g_v_total_chk
        $error("vga_scan_ctrl: vertical total exceeds 10-bit counter range");
    end

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_FP_START   = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] H_BP_START   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_FP_START   = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] V_BP_START   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    logic w_pix_tick;

    pix_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_en (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .o_pix_tick (w_pix_tick)
    );

    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    scan_phase_t      r_h_phase;
    scan_phase_t      r_v_phase;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_line_start;
    logic             r_frame_start;

    logic [CNT_W-1:0] w_hcount_d;
    logic [CNT_W-1:0] w_vcount_d;
    scan_phase_t      w_h_phase_d;
    scan_phase_t      w_v_phase_d;
    logic             w_hsync_d;
    logic             w_vsync_d;
    logic             w_video_on_d;
    logic             w_line_start_d;
    logic             w_frame_start_d;
    logic             w_h_wrap;
    logic             w_v_wrap;

    assign w_h_wrap = (r_hcount == H_LAST);
    assign w_v_wrap = (r_vcount == V_LAST);

    // Level outputs are computed from the new counter values so they line up
    // with hcount/vcount in the same cycle.
    always_comb begin
        w_hcount_d      = r_hcount;
        w_vcount_d      = r_vcount;
        w_h_phase_d     = r_h_phase;
        w_v_phase_d     = r_v_phase;
        w_hsync_d       = r_hsync;
        w_vsync_d       = r_vsync;
        w_video_on_d    = r_video_on;
        w_line_start_d  = w_pix_tick & w_h_wrap;
        w_frame_start_d = w_pix_tick & w_h_wrap & w_v_wrap;

        if (w_pix_tick) begin
            if (w_h_wrap) begin
                w_hcount_d = '0;
                w_vcount_d = w_v_wrap ? '0 : r_vcount + CNT_W'(1);
            end else begin
                w_hcount_d = r_hcount + CNT_W'(1);
            end

            w_h_phase_d = next_phase(r_h_phase, w_hcount_d,
                                     H_FP_START, H_SYNC_START, H_BP_START);
            if (w_h_wrap) begin
                w_v_phase_d = next_phase(r_v_phase, w_vcount_d,
                                         V_FP_START, V_SYNC_START, V_BP_START);
            end

            w_hsync_d    = (w_h_phase_d != SYNC);
            w_vsync_d    = (w_v_phase_d != SYNC);
            w_video_on_d = (w_h_phase_d == ACTIVE) && (w_v_phase_d == ACTIVE);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_h_phase     <= ACTIVE;
            r_v_phase     <= ACTIVE;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_hcount_d;
            r_vcount      <= w_vcount_d;
            r_h_phase     <= w_h_phase_d;
            r_v_phase     <= w_v_phase_d;
            r_hsync       <= w_hsync_d;
            r_vsync       <= w_vsync_d;
            r_video_on    <= w_video_on_d;
            r_line_start  <= w_line_start_d;
            r_frame_start <= w_frame_start_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_count <= '0;
        end else if (w_frame_start_d) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign o_frame_count = r_frame_count;
`endif

    assign o_pix_tick    = w_pix_tick;
    assign o_hcount      = r_hcount;
    assign o_vcount      = r_vcount;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_video_on    = r_video_on;
    // Markers are masked while paused so a held register never shows as a pulse.
    assign o_line_start  = r_line_start & i_en;
    assign o_frame_start = r_frame_start & i_en;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl using reduced timing so a full frame is short.
module tb_vga_scan_ctrl;

    localparam int CD = 2;
    localparam int HV = 20;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 6;
    localparam int VV = 10;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int LINE_CLKS  = HT * CD;
    localparam int FRAME_CLKS = HT * VT * CD;

    typedef struct packed {
        logic        tick;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        vid;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pix_tick;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        line_start;
    logic        frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    vga_scan_ctrl #(
        .CLK_DIV   (CD),
        .H_VISIBLE (HV),
        .H_FP      (HF),
        .H_SYNC    (HS),
        .H_BP      (HB),
        .V_VISIBLE (VV),
        .V_FP      (VF),
        .V_SYNC    (VS),
        .V_BP      (VB)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .o_pix_tick    (pix_tick),
        .o_hcount      (hcount),
        .o_vcount      (vcount),
        .o_hsync       (hsync),
        .o_vsync       (vsync),
        .o_video_on    (video_on),
        .o_line_start  (line_start),
        .o_frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
        ,
        .o_frame_count (frame_count)
`endif
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    obs_t sb[$];

    // Reference state, advanced once per clock edge from the driven inputs.
    int m_div  = 0;
    bit m_pend = 0;
    int m_h    = 0;
    int m_v    = 0;
    bit m_seen = 0;
    bit m_ls   = 0;
    bit m_fs   = 0;
    int m_fc   = 0;

    function automatic obs_t sample();
        obs_t s;
        s.tick = pix_tick;
        s.h    = hcount;
        s.v    = vcount;
        s.hs   = hsync;
        s.vs   = vsync;
        s.vid  = video_on;
        s.ls   = line_start;
        s.fs   = frame_start;
`ifdef VGA_FRAME_CNT_EN
        s.fc   = frame_count;
`else
        s.fc   = 16'd0;
`endif
        return s;
    endfunction

    task automatic drive(input logic r, input logic e);
        obs_t x;
        rst = r;
        en  = e;
        if (r) begin
            m_div = 0; m_pend = 0; m_h = 0; m_v = 0;
            m_seen = 0; m_ls = 0; m_fs = 0; m_fc = 0;
        end else if (e) begin
            m_ls = 0;
            m_fs = 0;
            if (m_pend) begin
                m_seen = 1;
                if (m_h == HT - 1) begin
                    m_h  = 0;
                    m_ls = 1;
                    if (m_v == VT - 1) begin
                        m_v  = 0;
                        m_fs = 1;
                        m_fc = (m_fc + 1) % 65536;
                    end else begin
                        m_v = m_v + 1;
                    end
                end else begin
                    m_h = m_h + 1;
                end
            end
            m_pend = (m_div == CD - 1);
            m_div  = (m_div + 1) % CD;
        end else begin
            m_ls = 0;
            m_fs = 0;
        end
        x.tick = m_pend & e;
        x.h    = 10'(m_h);
        x.v    = 10'(m_v);
        x.hs   = !(m_h >= HV + HF && m_h < HV + HF + HS);
        x.vs   = !(m_v >= VV + VF && m_v < VV + VF + VS);
        x.vid  = m_seen && (m_h < HV) && (m_v < VV);
        x.ls   = m_ls & e;
        x.fs   = m_fs & e;
`ifdef VGA_FRAME_CNT_EN
        x.fc   = 16'(m_fc);
`else
        x.fc   = 16'd0;
`endif
        sb.push_back(x);
    endtask

    task automatic step(input logic r, input logic e, output obs_t exp, output obs_t got);
        drive(r, e);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        got = sample();
    endtask

    task automatic test_reset();
        obs_t e, g;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, e, g);
            checks++;
            if (g !== e) begin errors++; $display("FAIL reset_sb: got %h expected %h", g, e); end
        end
        checks++;
        if ({g.tick, g.h, g.v, g.hs, g.vs, g.vid, g.ls, g.fs} !== {1'b0, 10'd0, 10'd0, 5'b11000})
        begin
            errors++;
            $display("FAIL reset_vals: got %h expected tick=0 h=0 v=0 hs=1 vs=1 vid=0", g);
        end
        step(1'b0, 1'b1, e, g);
        checks++;
        if (g.tick !== 1'b0) begin errors++; $display("FAIL tick_early: got %b expected 0", g.tick); end
        step(1'b0, 1'b1, e, g);
        checks++;
        if (g.tick !== 1'b1) begin errors++; $display("FAIL first_tick: got %b expected 1", g.tick); end
        checks++;
        if (g !== e) begin errors++; $display("FAIL release_sb: got %h expected %h", g, e); end
    endtask

    task automatic test_line();
        obs_t e, g;
        int n = 0, vid_ticks = 0, hs_ticks = 0, hs_min = 1023, hs_max = 0;
        int ls_cnt = 0, last_h = -1, ls_prev_h = -1;
        do begin
            step(1'b0, 1'b1, e, g);
            checks++;
            if (g !== e) begin errors++; $display("FAIL line_sb: got %h expected %h", g, e); end
            n++;
        end while (!g.ls && n < 2 * LINE_CLKS + 4);
        checks++;
        if (g.ls !== 1'b1) begin errors++; $display("FAIL line_wait: got %b expected 1", g.ls); end
        for (int i = 0; i < LINE_CLKS; i++) begin
            step(1'b0, 1'b1, e, g);
            checks++;
            if (g !== e) begin errors++; $display("FAIL line_sb: got %h expected %h", g, e); end
            if (g.ls) begin ls_cnt++; ls_prev_h = last_h; end
            if (g.tick) begin
                if (g.vid) vid_ticks++;
                if (!g.hs) begin
                    hs_ticks++;
                    if (int'(g.h) < hs_min) hs_min = int'(g.h);
                    if (int'(g.h) > hs_max) hs_max = int'(g.h);
                end
                last_h = int'(g.h);
            end
        end
        checks++;
        if (vid_ticks != HV) begin errors++; $display("FAIL line_video: got %0d expected %0d", vid_ticks, HV); end
        checks++;
        if (hs_ticks != HS) begin errors++; $display("FAIL line_hs_len: got %0d expected %0d", hs_ticks, HS); end
        checks++;
        if (hs_min != HV + HF || hs_max != HV + HF + HS - 1) begin
            errors++;
            $display("FAIL line_hs_span: got %0d..%0d expected %0d..%0d",
                     hs_min, hs_max, HV + HF, HV + HF + HS - 1);
        end
        checks++;
        if (ls_cnt != 1) begin errors++; $display("FAIL line_ls_cnt: got %0d expected 1", ls_cnt); end
        checks++;
        if (ls_prev_h != HT - 1) begin errors++; $display("FAIL line_ls_at: got %0d expected %0d", ls_prev_h, HT - 1); end
    endtask

    task automatic test_frame();
        obs_t e, g;
        int n = 0, fs_cnt = 0, vs_min = 1023, vs_max = 0, max_v = 0;
        int last_h = -1, last_v = -1, fs_h = -1, fs_v = -1;
        do begin
            step(1'b0, 1'b1, e, g);
            checks++;
            if (g !== e) begin errors++; $display("FAIL frame_sb: got %h expected %h", g, e); end
            n++;
        end while (!g.fs && n < FRAME_CLKS + 8);
        checks++;
        if (g.fs !== 1'b1) begin errors++; $display("FAIL frame_wait: got %b expected 1", g.fs); end
        for (int i = 0; i < FRAME_CLKS; i++) begin
            step(1'b0, 1'b1, e, g);
            checks++;
            if (g !== e) begin errors++; $display("FAIL frame_sb: got %h expected %h", g, e); end
            if (int'(g.v) > max_v) max_v = int'(g.v);
            if (g.fs) begin fs_cnt++; fs_h = last_h; fs_v = last_v; end
            if (g.tick) begin
                if (!g.vs) begin
                    if (int'(g.v) < vs_min) vs_min = int'(g.v);
                    if (int'(g.v) > vs_max) vs_max = int'(g.v);
                end
                last_h = int'(g.h);
                last_v = int'(g.v);
            end
        end
        checks++;
        if (fs_cnt != 1) begin errors++; $display("FAIL frame_fs_cnt: got %0d expected 1", fs_cnt); end
        checks++;
        if (fs_h != HT - 1 || fs_v != VT - 1) begin
            errors++;
            $display("FAIL frame_fs_at: got (%0d,%0d) expected (%0d,%0d)", fs_h, fs_v, HT - 1, VT - 1);
        end
        checks++;
        if (vs_min != VV + VF || vs_max != VV + VF + VS - 1) begin
            errors++;
            $display("FAIL frame_vs_span: got %0d..%0d expected %0d..%0d",
                     vs_min, vs_max, VV + VF, VV + VF + VS - 1);
        end
        checks++;
        if (max_v != VT - 1) begin errors++; $display("FAIL frame_vmax: got %0d expected %0d", max_v, VT - 1); end
    endtask

    task automatic test_pause();
        obs_t e, g;
        int n = 0, bad = 0;
        do begin
            step(1'b0, 1'b1, e, g);
            checks++;
            if (g !== e) begin errors++; $display("FAIL pause_sb: got %h expected %h", g, e); end
            n++;
        end while (g.h !== 10'd10 && n < 2 * LINE_CLKS);
        checks++;
        if (g.h !== 10'd10) begin errors++; $display("FAIL pause_wait: got %0d expected 10", g.h); end
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, e, g);
            checks++;
            if (g !== e) begin errors++; $display("FAIL pause_sb: got %h expected %h", g, e); end
            if (g.h !== 10'd10 || g.tick || g.ls || g.fs) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL pause_hold: got %0d bad cycles expected 0", bad); end
        n = 0;
        do begin
            step(1'b0, 1'b1, e, g);
            checks++;
            if (g !== e) begin errors++; $display("FAIL resume_sb: got %h expected %h", g, e); end
            n++;
        end while (g.h === 10'd10 && n < 4 * CD);
        checks++;
        if (g.h !== 10'd11) begin errors++; $display("FAIL resume_h: got %0d expected 11", g.h); end
    endtask

    task automatic test_reset_mid();
        obs_t e, g;
        int n = 0, fs_cnt = 0, first_h = -1;
        do begin
            step(1'b0, 1'b1, e, g);
            checks++;
            if (g !== e) begin errors++; $display("FAIL rmid_sb: got %h expected %h", g, e); end
            n++;
        end while (!(g.h === 10'd30 && g.v === 10'd7) && n < FRAME_CLKS + 8);
        checks++;
        if (g.h !== 10'd30 || g.v !== 10'd7) begin
            errors++; $display("FAIL rmid_wait: got (%0d,%0d) expected (30,7)", g.h, g.v);
        end
        step(1'b1, 1'b1, e, g);
        checks++;
        if ({g.tick, g.h, g.v, g.hs, g.vs, g.vid, g.ls, g.fs} !== {1'b0, 10'd0, 10'd0, 5'b11000})
        begin
            errors++;
            $display("FAIL rmid_vals: got %h expected tick=0 h=0 v=0 hs=1 vs=1 vid=0 ls=0 fs=0", g);
        end
        for (int i = 0; i < 2 * LINE_CLKS; i++) begin
            step(1'b0, 1'b1, e, g);
            checks++;
            if (g !== e) begin errors++; $display("FAIL rmid_sb: got %h expected %h", g, e); end
            if (g.fs) fs_cnt++;
            if (g.tick && first_h < 0) first_h = int'(g.h);
        end
        checks++;
        if (fs_cnt != 0) begin errors++; $display("FAIL rmid_no_fs: got %0d expected 0", fs_cnt); end
        checks++;
        if (first_h != 0) begin errors++; $display("FAIL rmid_restart: got %0d expected 0", first_h); end
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        obs_t e, g;
        for (int f = 1; f <= 2; f++) begin
            int n = 0;
            do begin
                step(1'b0, 1'b1, e, g);
                checks++;
                if (g !== e) begin errors++; $display("FAIL fcnt_sb: got %h expected %h", g, e); end
                n++;
            end while (!g.fs && n < FRAME_CLKS + 8);
            checks++;
            if (g.fs !== 1'b1 || g.fc !== 16'(f)) begin
                errors++; $display("FAIL fcnt_val: got fs=%b fc=%0d expected fs=1 fc=%0d", g.fs, g.fc, f);
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        test_reset();
        test_line();
        test_frame();
        test_pause();
        test_reset_mid();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
